// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the MMIO word tracer (mmio_uart_tx).
// Byte-per-word derivation covers both the raw and MMIO_UART_HEX_EN builds.
package mmio_uart_pkg;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;
  localparam logic [7:0] ASCII_NEWLINE    = 8'h0A;

  function automatic int bytes_per_word(input int bus_width, input bit hex_en);
    return hex_en ? (bus_width / 4 + 1) : (bus_width / 8);
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_DIGIT_BASE + {4'd0, nib};
    return ASCII_ALPHA_BASE + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO; a push into a full FIFO is accepted only when a pop
// happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Captures every change of the MMIO word and streams it over 8N1 to the AVR.
// Define MMIO_UART_HEX_EN to send ASCII hex digits plus newline instead of raw bytes.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int BUS_WIDTH    = 32,
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] io_word,
  input  logic                 avr_rx_busy,
  output logic                 avr_rx,
  output logic                 busy,
  output logic                 overflow
);

`ifdef MMIO_UART_HEX_EN
  localparam bit HEX_EN  = 1'b1;
  localparam int NIBBLES = BUS_WIDTH / 4;
`else
  localparam bit HEX_EN  = 1'b0;
`endif
  localparam int BPW   = bytes_per_word(BUS_WIDTH, HEX_EN);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  function automatic logic [7:0] word_byte(input logic [BUS_WIDTH-1:0] w,
                                           input logic [IDX_W-1:0]     idx);
    logic [BUS_WIDTH-1:0] sh;
`ifdef MMIO_UART_HEX_EN
    if (int'(idx) >= NIBBLES) return ASCII_NEWLINE;
    sh = w >> (4 * (NIBBLES - 1 - int'(idx)));
    return hex_ascii(sh[3:0]);
`else
    sh = w >> (8 * (BPW - 1 - int'(idx)));
    return sh[7:0];
`endif
  endfunction

  logic [BUS_WIDTH-1:0] io_word_p0;
  logic                 word_chg;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [BUS_WIDTH-1:0] fifo_rd_data;

  ser_state_e           state;
  ser_state_e           state_nxt;
  logic                 load;
  logic                 bit_end;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift_reg;
  logic [BUS_WIDTH-1:0] word_reg;
  logic [IDX_W-1:0]     byte_idx;
  logic                 word_vld;
  logic [BUS_WIDTH-1:0] sel_word;
  logic [IDX_W-1:0]     sel_idx;
  logic                 tx_line;

  // Capture stage: compare against last sample, push on any difference
  assign word_chg = (io_word != io_word_p0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_word_p0 <= '0;
      overflow   <= 1'b0;
    end else begin
      io_word_p0 <= io_word;
      if (word_chg && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (word_chg),
    .pop     (fifo_pop),
    .wr_data (io_word),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Serializer stage: unsent bytes of the held word take priority over a pop
  assign bit_end  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign sel_word = word_vld ? word_reg : fifo_rd_data;
  assign sel_idx  = word_vld ? byte_idx : '0;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      SER_IDLE: begin
        if (!avr_rx_busy && (word_vld || !fifo_empty)) begin
          load      = 1'b1;
          fifo_pop  = !word_vld;
          state_nxt = SER_START;
        end
      end
      SER_START: if (bit_end) state_nxt = SER_DATA;
      SER_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = SER_STOP;
      SER_STOP:  if (bit_end) state_nxt = SER_IDLE;
      default:   state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SER_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word_vld <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      clk_cnt <= (state == SER_IDLE || bit_end) ? '0 : clk_cnt + CNT_W'(1);
      if (load) begin
        bit_idx  <= '0;
        word_vld <= (sel_idx != IDX_W'(BPW - 1));
        byte_idx <= (sel_idx == IDX_W'(BPW - 1)) ? '0 : sel_idx + IDX_W'(1);
      end else if (state == SER_DATA && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
      // Line is registered, so it trails the state by exactly one cycle
      case (state)
        SER_START: tx_line <= 1'b0;
        SER_DATA:  tx_line <= shift_reg[0];
        default:   tx_line <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shift_reg <= word_byte(sel_word, sel_idx);
      if (fifo_pop) word_reg <= fifo_rd_data;
    end else if (state == SER_DATA && bit_end) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  assign avr_rx = tx_line;
  assign busy   = !fifo_empty || (state != SER_IDLE) || word_vld;

endmodule
